// File: rtl/gyro_integrator_pkg.sv
// ---------------------------------------------------------------------------
// gyro_integrator_pkg
// Shared definitions for the gyro angle integrator:
//   - FSM state encodings (IDLE/CAL/DIV/RUN), matching the debug 'state' port
//   - phase encodings for the time-multiplexed per-axis datapath
//   - axis index constants AX_X/AX_Y/AX_Z
//   - 16-bit signed min/max constants
//   - phase_axis(): which axis the shared datapath serves in a given phase
// ---------------------------------------------------------------------------
package gyro_integrator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // PH_X/PH_Y/PH_Z: that axis accumulates at the coming edge.
    // PH_OUT: angles are published at the coming edge.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_X    = 3'd1,
        PH_Y    = 3'd2,
        PH_Z    = 3'd3,
        PH_OUT  = 3'd4
    } phase_e;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] S16_MIN = 16'sh8000;

    function automatic logic [1:0] phase_axis(input phase_e ph);
        case (ph)
            PH_Y:    return AX_Y;
            PH_Z:    return AX_Z;
            default: return AX_X;
        endcase
    endfunction

endpackage

// File: rtl/gyro_rate_correct.sv
// ---------------------------------------------------------------------------
// gyro_rate_correct
// Purely combinational bias removal for one axis: d = rate - bias in 17 bits,
// saturated to 16-bit signed, then forced to 0 inside the deadband.
// Ports:
//   rate_i  in  16  signed raw rate
//   bias_i  in  16  signed zero-rate bias
//   d_o     out 16  signed corrected, deadbanded rate
// ---------------------------------------------------------------------------
module gyro_rate_correct
    import gyro_integrator_pkg::*;
#(
    parameter int DEADBAND = 8
) (
    input  logic signed [15:0] rate_i,
    input  logic signed [15:0] bias_i,
    output logic signed [15:0] d_o
);

    localparam logic signed [16:0] DIFF_HI = 17'sd32767;
    localparam logic signed [16:0] DIFF_LO = -17'sd32768;

    logic signed [16:0] diff;
    logic signed [15:0] sat;
    logic        [16:0] mag;

    always_comb begin
        diff = {rate_i[15], rate_i} - {bias_i[15], bias_i};
        if (diff > DIFF_HI) begin
            sat = S16_MAX;
        end else if (diff < DIFF_LO) begin
            sat = S16_MIN;
        end else begin
            sat = diff[15:0];
        end
        // 17-bit magnitude so that -32768 does not wrap back to negative
        mag = sat[15] ? (17'd0 - {1'b1, sat}) : {1'b0, sat};
        d_o = (mag <= 17'(DEADBAND)) ? 16'sd0 : sat;
    end

endmodule

// File: rtl/gyro_integrator.sv
// ---------------------------------------------------------------------------
// gyro_integrator
// Calibrates a per-axis zero-rate bias by averaging 2^CAL_LOG2 samples, then
// integrates bias-corrected, deadbanded rates into saturating accumulators
// and publishes acc >>> SHIFT (saturated to 16 bits) as the angle outputs.
// A single correction/accumulate datapath is shared X -> Y -> Z.
// Ports:
//   clk           in   1   system clock
//   RST           in   1   asynchronous active-low reset
//   sample_valid  in   1   strobe: x/y/z_rate hold a new sample
//   x/y/z_rate    in   16  signed rates
//   cal_start     in   1   begin/restart calibration
//   zero_angles   in   1   clear all accumulators
//   ang_x/y/z     out  16  signed registered angles
//   out_valid     out  1   one-cycle pulse when ang_* update
//   cal_done      out  1   high while in RUN
//   overrun       out  1   sticky: sample dropped while busy
//   state         out  2   debug state (0 IDLE, 1 CAL, 2 DIV, 3 RUN)
// ---------------------------------------------------------------------------
module gyro_integrator
    import gyro_integrator_pkg::*;
#(
    parameter int CAL_LOG2 = 6,
    parameter int DEADBAND = 8,
    parameter int SHIFT    = 7,
    parameter int ACC_W    = 32
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               sample_valid,
    input  logic signed [15:0] x_rate,
    input  logic signed [15:0] y_rate,
    input  logic signed [15:0] z_rate,
    input  logic               cal_start,
    input  logic               zero_angles,
    output logic signed [15:0] ang_x,
    output logic signed [15:0] ang_y,
    output logic signed [15:0] ang_z,
    output logic               out_valid,
    output logic               cal_done,
    output logic               overrun,
    output logic [1:0]         state
);

    localparam int SUM_W = 16 + CAL_LOG2;
    localparam int CNT_W = CAL_LOG2 + 1;
    localparam logic [CNT_W-1:0]        CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ANG_HI   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] ANG_LO   = ACC_W'(-32768);

    state_e                  state_q;
    phase_e                  phase_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [SUM_W-1:0] sum_q  [3];
    logic signed [15:0]      bias_q [3];
    logic signed [15:0]      rate_q [3];
    logic signed [ACC_W-1:0] acc_q  [3];
    logic signed [15:0]      ang_q  [3];
    logic                    out_valid_q;
    logic                    cal_done_q;
    logic                    overrun_q;

    logic signed [15:0]      rate_in [3];
    logic [1:0]              axis_sel;
    logic                    busy;
    phase_e                  phase_d;
    logic signed [15:0]      corr_d;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W-1:0] acc_d;

    function automatic logic signed [15:0] to_ang(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > ANG_HI) return S16_MAX;
        if (s < ANG_LO) return S16_MIN;
        return s[15:0];
    endfunction

    always_comb begin
        rate_in[0] = x_rate;
        rate_in[1] = y_rate;
        rate_in[2] = z_rate;
    end

    // Phase sequencing and axis mux for the shared datapath
    always_comb begin
        axis_sel = phase_axis(phase_q);
        busy     = (phase_q == PH_X) || (phase_q == PH_Y) || (phase_q == PH_Z);
        case (phase_q)
            PH_X:    phase_d = PH_Y;
            PH_Y:    phase_d = PH_Z;
            PH_Z:    phase_d = PH_OUT;
            default: phase_d = PH_IDLE;
        endcase
    end

    gyro_rate_correct #(
        .DEADBAND (DEADBAND)
    ) u_rate_correct (
        .rate_i (rate_q[axis_sel]),
        .bias_i (bias_q[axis_sel]),
        .d_o    (corr_d)
    );

    // Saturating accumulate: one extra bit exposes overflow in either direction
    always_comb begin
        acc_ext = {acc_q[axis_sel][ACC_W-1], acc_q[axis_sel]}
                + {{(ACC_W+1-16){corr_d[15]}}, corr_d};
        if (acc_ext[ACC_W] != acc_ext[ACC_W-1]) begin
            acc_d = acc_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_d = acc_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            cal_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i]  <= '0;
                bias_q[i] <= '0;
                rate_q[i] <= '0;
                acc_q[i]  <= '0;
                ang_q[i]  <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (cal_start) begin
                // Restart from any state; in-flight axis work is abandoned
                state_q    <= ST_CAL;
                phase_q    <= PH_IDLE;
                cnt_q      <= '0;
                cal_done_q <= 1'b0;
                overrun_q  <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    sum_q[i] <= '0;
                    acc_q[i] <= '0;
                    ang_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    ST_CAL: begin
                        if (sample_valid) begin
                            for (int i = 0; i < 3; i++) begin
                                sum_q[i] <= sum_q[i] + {{CAL_LOG2{rate_in[i][15]}}, rate_in[i]};
                            end
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CAL_LAST) begin
                                state_q <= ST_DIV;
                            end
                        end
                    end
                    ST_DIV: begin
                        // Arithmetic shift: average rounded toward -inf
                        for (int i = 0; i < 3; i++) begin
                            bias_q[i] <= 16'(sum_q[i] >>> CAL_LOG2);
                            acc_q[i]  <= '0;
                        end
                        state_q    <= ST_RUN;
                        cal_done_q <= 1'b1;
                    end
                    ST_RUN: begin
                        if (busy) begin
                            acc_q[axis_sel] <= acc_d;
                            phase_q         <= phase_d;
                            if (sample_valid) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            if (phase_q == PH_OUT) begin
                                for (int i = 0; i < 3; i++) begin
                                    ang_q[i] <= to_ang(acc_q[i]);
                                end
                                out_valid_q <= 1'b1;
                            end
                            if (sample_valid) begin
                                for (int i = 0; i < 3; i++) begin
                                    rate_q[i] <= rate_in[i];
                                end
                                phase_q <= PH_X;
                            end else begin
                                phase_q <= PH_IDLE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase

                // Placed last so the clear overrides a coincident accumulate
                if (zero_angles) begin
                    overrun_q <= 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        acc_q[i] <= '0;
                    end
                    if (state_q == ST_RUN && !busy) begin
                        for (int i = 0; i < 3; i++) begin
                            ang_q[i] <= '0;
                        end
                        out_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign ang_x     = ang_q[0];
    assign ang_y     = ang_q[1];
    assign ang_z     = ang_q[2];
    assign out_valid = out_valid_q;
    assign cal_done  = cal_done_q;
    assign overrun   = overrun_q;
    assign state     = state_q;

endmodule

// File: tb/tb_gyro_integrator.sv
// ---------------------------------------------------------------------------
// tb_gyro_integrator
// Directed bench for gyro_integrator with CAL_LOG2=2, ACC_W=20, DEADBAND=8,
// SHIFT=7. Inputs change on the falling edge; outputs are checked on the
// falling edge, half a cycle after the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_gyro_integrator;

    logic               clk = 1'b0;
    logic               RST = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] x_rate = '0;
    logic signed [15:0] y_rate = '0;
    logic signed [15:0] z_rate = '0;
    logic               cal_start = 1'b0;
    logic               zero_angles = 1'b0;
    logic signed [15:0] ang_x;
    logic signed [15:0] ang_y;
    logic signed [15:0] ang_z;
    logic               out_valid;
    logic               cal_done;
    logic               overrun;
    logic [1:0]         state;

    int errors = 0;
    int checks = 0;

    gyro_integrator #(
        .CAL_LOG2 (2),
        .DEADBAND (8),
        .SHIFT    (7),
        .ACC_W    (20)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .sample_valid (sample_valid),
        .x_rate       (x_rate),
        .y_rate       (y_rate),
        .z_rate       (z_rate),
        .cal_start    (cal_start),
        .zero_angles  (zero_angles),
        .ang_x        (ang_x),
        .ang_y        (ang_y),
        .ang_z        (ang_z),
        .out_valid    (out_valid),
        .cal_done     (cal_done),
        .overrun      (overrun),
        .state        (state)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle sample strobe; returns on the falling edge after the capture edge
    task automatic applyStimulus(input logic signed [15:0] x, input logic signed [15:0] y,
                                 input logic signed [15:0] z);
        @(negedge clk);
        sample_valid = 1'b1;
        x_rate = x;
        y_rate = y;
        z_rate = z;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulseCal();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    task automatic pulseZero();
        @(negedge clk);
        zero_angles = 1'b1;
        @(negedge clk);
        zero_angles = 1'b0;
    endtask

    // Index 1 is the falling edge right after the capture edge k; out_valid
    // belongs at index 5 (the falling edge after k+4)
    task automatic waitUpdate(input string tag, input int startIdx, input int expIdx);
        int n;
        n = startIdx;
        while (out_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, n, expIdx);
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_ang_x", ang_x, 0);
        checkOutput("rst_ang_y", ang_y, 0);
        checkOutput("rst_ang_z", ang_z, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_cal_done", cal_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        @(negedge clk);
        RST = 1'b1;

        // IDLE ignores samples
        applyStimulus(16'sd100, 16'sd100, 16'sd100);
        checkOutput("idle_state", state, 0);

        // Start calibration, then reset asynchronously after 2 samples
        pulseCal();
        checkOutput("cal_state", state, 1);
        applyStimulus(16'sd1000, 16'sd1000, 16'sd1000);
        applyStimulus(16'sd1000, 16'sd1000, 16'sd1000);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("midrst_state", state, 0);
        checkOutput("midrst_cal_done", cal_done, 0);
        checkOutput("midrst_ang_x", ang_x, 0);
        @(negedge clk);
        RST = 1'b1;

        // Full calibration: biases 10 / -20 / 0
        pulseCal();
        applyStimulus(16'sd10, -16'sd20, 16'sd0);
        applyStimulus(16'sd10, -16'sd20, 16'sd0);
        applyStimulus(16'sd10, -16'sd20, 16'sd0);
        checkOutput("cal3_state", state, 1);
        applyStimulus(16'sd10, -16'sd20, 16'sd0);
        checkOutput("cal4_state_div", state, 2);
        @(negedge clk);
        checkOutput("cal_state_run", state, 3);
        checkOutput("cal_done", cal_done, 1);
        checkOutput("cal_ang_x", ang_x, 0);
        checkOutput("cal_ang_y", ang_y, 0);

        // Bias check: corrected d = 128 / 256 / 384 -> angles 1 / 2 / 3
        applyStimulus(16'sd138, 16'sd236, 16'sd384);
        waitUpdate("bias", 1, 5);
        checkOutput("bias_ang_x", ang_x, 1);
        checkOutput("bias_ang_y", ang_y, 2);
        checkOutput("bias_ang_z", ang_z, 3);
        @(negedge clk);
        checkOutput("bias_out_valid_pulse", out_valid, 0);

        // Recalibrate on zero samples; cal_start clears the angles
        pulseCal();
        checkOutput("recal_ang_x", ang_x, 0);
        checkOutput("recal_state", state, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'sd0, 16'sd0, 16'sd0);
        end
        @(negedge clk);
        checkOutput("recal_run", state, 3);

        // Integration: 4 x 128 -> acc 512 -> angle 4
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'sd128, 16'sd0, 16'sd0);
            waitUpdate("integ", 1, 5);
        end
        checkOutput("integ_ang_x", ang_x, 4);
        checkOutput("integ_ang_y", ang_y, 0);
        checkOutput("integ_ang_z", ang_z, 0);

        // zero_angles while idle takes effect immediately with a pulse
        pulseZero();
        checkOutput("zero_idle_out_valid", out_valid, 1);
        checkOutput("zero_idle_ang_x", ang_x, 0);

        // Deadband boundary: |d| <= 8 ignored, 9 counted
        applyStimulus(16'sd128, 16'sd0, 16'sd0);
        waitUpdate("db", 1, 5);
        checkOutput("db_base", ang_x, 1);
        applyStimulus(-16'sd8, 16'sd0, 16'sd0);
        waitUpdate("db", 1, 5);
        checkOutput("db_neg8", ang_x, 1);
        applyStimulus(16'sd8, 16'sd0, 16'sd0);
        waitUpdate("db", 1, 5);
        checkOutput("db_pos8", ang_x, 1);
        applyStimulus(-16'sd9, 16'sd0, 16'sd0);
        waitUpdate("db", 1, 5);
        checkOutput("db_neg9", ang_x, 0);
        applyStimulus(16'sd9, 16'sd0, 16'sd0);
        waitUpdate("db", 1, 5);
        checkOutput("db_pos9", ang_x, 1);

        // Overrun: back-to-back strobes, second one dropped (acc 128 -> 256)
        @(negedge clk);
        sample_valid = 1'b1;
        x_rate = 16'sd128;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        waitUpdate("ovr", 2, 5);
        checkOutput("ovr_ang_x", ang_x, 2);
        checkOutput("ovr_flag", overrun, 1);
        pulseZero();
        checkOutput("ovr_zero_ang_x", ang_x, 0);
        checkOutput("ovr_zero_flag", overrun, 0);

        // zero_angles on the X accumulate edge discards X only
        applyStimulus(16'sd128, 16'sd128, 16'sd128);
        zero_angles = 1'b1;
        @(negedge clk);
        zero_angles = 1'b0;
        checkOutput("zbusy_no_pulse", out_valid, 0);
        waitUpdate("zbusy", 2, 5);
        checkOutput("zbusy_ang_x", ang_x, 0);
        checkOutput("zbusy_ang_y", ang_y, 1);
        checkOutput("zbusy_ang_z", ang_z, 1);

        // Saturation at the 20-bit limits, then step back without wrap
        pulseZero();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'sd32767, -16'sd32768, 16'sd0);
            waitUpdate("sat", 1, 5);
        end
        checkOutput("sat_ang_x", ang_x, 4095);
        checkOutput("sat_ang_y", ang_y, -4096);
        checkOutput("sat_ang_z", ang_z, 0);
        applyStimulus(-16'sd32768, 16'sd32767, 16'sd0);
        waitUpdate("unsat", 1, 5);
        checkOutput("unsat_ang_x", ang_x, 3839);
        checkOutput("unsat_ang_y", ang_y, -3841);

        // cal_start in RUN clears overrun, cal_done and angles
        @(negedge clk);
        sample_valid = 1'b1;
        x_rate = 16'sd128;
        y_rate = 16'sd0;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        waitUpdate("runcal", 2, 5);
        checkOutput("runcal_ang_x", ang_x, 3840);
        checkOutput("runcal_overrun_set", overrun, 1);
        pulseCal();
        checkOutput("runcal_state", state, 1);
        checkOutput("runcal_overrun", overrun, 0);
        checkOutput("runcal_cal_done", cal_done, 0);
        checkOutput("runcal_ang_x0", ang_x, 0);
        checkOutput("runcal_ang_y0", ang_y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
